// File: rtl/aes_mixcolumns_seq.sv
// Sequences one shared 32-bit aes_mixcolumns instance over a 128-bit AES state,
// one column per clock, with start/busy on the input side and valid/ready on the output.
module aes_mixcolumns_seq #(
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         enc,
  input  logic         bypass,
  input  logic [127:0] state_in,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         mc_enc,
  output logic [31:0]  mc_in,
  input  logic [31:0]  mc_out
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e       state_q, state_d;
  logic [1:0]   col_q, col_d;
  logic [127:0] data_q, data_d;
  logic         enc_q, enc_d;
  logic [127:0] out_q, out_d;

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    data_d  = data_q;
    enc_d   = enc_q;
    out_d   = out_q;
    mc_in   = 32'h0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          data_d = state_in;
          enc_d  = enc;
          col_d  = 2'd0;
          if (bypass && BYPASS_EN) begin
            out_d   = state_in;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        // Each mixed column overwrites its source column in place; state_out is
        // only updated once the last column is back, so it never shows a partial result.
        unique case (col_q)
          2'd0: begin mc_in = data_q[127:96]; data_d[127:96] = mc_out; end
          2'd1: begin mc_in = data_q[95:64];  data_d[95:64]  = mc_out; end
          2'd2: begin mc_in = data_q[63:32];  data_d[63:32]  = mc_out; end
          default: begin mc_in = data_q[31:0]; data_d[31:0] = mc_out; end
        endcase
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) begin
          out_d   = {data_q[127:32], mc_out};
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      data_q  <= 128'h0;
      enc_q   <= 1'b0;
      out_q   <= 128'h0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      data_q  <= data_d;
      enc_q   <= enc_d;
      out_q   <= out_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign state_out = out_q;
  assign mc_enc    = enc_q;

endmodule

// File: tb/tb_aes_mixcolumns_seq.sv
// Directed bench for aes_mixcolumns_seq; a small GF(2^8) column model stands in
// for the external aes_mixcolumns instance.
module tb_aes_mixcolumns_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, start2, enc, bypass, out_ready;
  logic [127:0] state_in;
  logic         busy, out_valid, mc_enc;
  logic [127:0] state_out;
  logic [31:0]  mc_in, mc_out;
  logic         busy2, out_valid2, mc_enc2;
  logic [127:0] state_out2;
  logic [31:0]  mc_in2, mc_out2;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] FIPS_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [127:0] WIKI_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] WIKI_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] BYP_IN   = 128'h00112233_44556677_8899aabb_ccddeeff;

  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] r = 8'h00;
    logic [7:0] p = a;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) r ^= p;
      p = xt(p);
    end
    return r;
  endfunction

  function automatic logic [31:0] mix(input logic [31:0] col, input logic e);
    logic [3:0] c [4];
    logic [7:0] a [4];
    logic [7:0] r;
    logic [31:0] res = 32'h0;
    if (e) begin c[0] = 4'h2; c[1] = 4'h3; c[2] = 4'h1; c[3] = 4'h1; end
    else   begin c[0] = 4'he; c[1] = 4'hb; c[2] = 4'hd; c[3] = 4'h9; end
    for (int j = 0; j < 4; j++) a[j] = col[31-8*j -: 8];
    for (int i = 0; i < 4; i++) begin
      r = 8'h00;
      for (int j = 0; j < 4; j++) r ^= gmul(a[j], c[(j - i) & 3]);
      res[31-8*i -: 8] = r;
    end
    return res;
  endfunction

  function automatic logic [31:0] col_of(input logic [127:0] d, input int i);
    return d[32*(3-i) +: 32];
  endfunction

  always_comb mc_out  = mix(mc_in, mc_enc);
  always_comb mc_out2 = mix(mc_in2, mc_enc2);

  aes_mixcolumns_seq #(.BYPASS_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .enc(enc), .bypass(bypass),
    .state_in(state_in), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .state_out(state_out), .mc_enc(mc_enc), .mc_in(mc_in), .mc_out(mc_out)
  );

  aes_mixcolumns_seq #(.BYPASS_EN(1'b0)) u_dut_nobyp (
    .clk(clk), .rst_n(rst_n), .start(start2), .enc(enc), .bypass(bypass),
    .state_in(state_in), .busy(busy2), .out_valid(out_valid2), .out_ready(out_ready),
    .state_out(state_out2), .mc_enc(mc_enc2), .mc_in(mc_in2), .mc_out(mc_out2)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts one non-bypass op, checks the column stream and latency, then drains it.
  task automatic run_op(input string tag, input logic e, input logic [127:0] din,
                        input logic [127:0] dexp);
    enc = e; bypass = 1'b0; state_in = din; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " busy after accept"}, busy, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s mc_in col%0d", tag, i), mc_in, col_of(din, i));
      check($sformatf("%s mc_enc col%0d", tag, i), mc_enc, e);
      check($sformatf("%s out_valid early col%0d", tag, i), out_valid, 1'b0);
      tick();
    end
    check({tag, " out_valid"}, out_valid, 1'b1);
    check({tag, " state_out"}, state_out, dexp);
    check({tag, " mc_in quiet in DONE"}, mc_in, 32'h0);
    tick();
    check({tag, " out_valid after handshake"}, out_valid, 1'b0);
    check({tag, " busy after handshake"}, busy, 1'b0);
    check({tag, " state_out held"}, state_out, dexp);
  endtask

  initial begin
    logic [127:0] exp_byp0;
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; enc = 1'b0; bypass = 1'b0;
    out_ready = 1'b0; state_in = '0;
    tick(); tick();
    check("reset busy", busy, 1'b0);
    check("reset out_valid", out_valid, 1'b0);
    check("reset state_out", state_out, 128'h0);
    check("reset mc_in", mc_in, 32'h0);
    check("reset mc_enc", mc_enc, 1'b0);
    rst_n = 1'b1;
    tick();

    run_op("enc fips", 1'b1, FIPS_IN, FIPS_OUT);
    run_op("dec fips", 1'b0, FIPS_OUT, FIPS_IN);
    run_op("enc db13", 1'b1, WIKI_IN, WIKI_OUT);

    // Bypass: latency 1, state passes through, the column bus never moves.
    enc = 1'b1; bypass = 1'b1; state_in = BYP_IN; out_ready = 1'b1; start = 1'b1;
    check("bypass mc_in idle", mc_in, 32'h0);
    tick();
    start = 1'b0;
    check("bypass out_valid", out_valid, 1'b1);
    check("bypass state_out", state_out, BYP_IN);
    check("bypass mc_in", mc_in, 32'h0);
    tick();
    check("bypass done", out_valid, 1'b0);
    check("bypass busy", busy, 1'b0);

    // Same stimulus on the instance with bypass disabled runs all four columns.
    exp_byp0 = {mix(col_of(BYP_IN, 0), 1'b1), mix(col_of(BYP_IN, 1), 1'b1),
                mix(col_of(BYP_IN, 2), 1'b1), mix(col_of(BYP_IN, 3), 1'b1)};
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("nobyp mc_in col%0d", i), mc_in2, col_of(BYP_IN, i));
      check($sformatf("nobyp out_valid early %0d", i), out_valid2, 1'b0);
      tick();
    end
    check("nobyp out_valid", out_valid2, 1'b1);
    check("nobyp state_out", state_out2, exp_byp0);
    bypass = 1'b0;
    tick();
    check("nobyp done", out_valid2, 1'b0);

    // Backpressure with start pulses while busy.
    enc = 1'b1; state_in = FIPS_IN; out_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    enc = 1'b0; state_in = BYP_IN; start = 1'b1;
    tick();
    start = 1'b0;
    check("bp mc_in not relatched", mc_in, col_of(FIPS_IN, 2));
    tick(); tick();
    for (int i = 0; i < 6; i++) begin
      start = (i == 2);
      check($sformatf("bp out_valid %0d", i), out_valid, 1'b1);
      check($sformatf("bp busy %0d", i), busy, 1'b1);
      check($sformatf("bp state_out %0d", i), state_out, FIPS_OUT);
      tick();
    end
    start = 1'b0;
    check("bp after start in DONE", state_out, FIPS_OUT);
    // Handshake and start in the same cycle: start ignored, accepted one cycle later.
    out_ready = 1'b1; enc = 1'b0; state_in = FIPS_OUT; start = 1'b1;
    tick();
    check("bp handshake out_valid", out_valid, 1'b0);
    check("bp handshake busy", busy, 1'b0);
    tick();
    start = 1'b0;
    check("b2b busy", busy, 1'b1);
    check("b2b mc_in col0", mc_in, col_of(FIPS_OUT, 0));
    tick(); tick(); tick(); tick();
    check("b2b out_valid", out_valid, 1'b1);
    check("b2b state_out", state_out, FIPS_IN);
    tick();

    // Asynchronous reset during col=2 aborts the op immediately.
    enc = 1'b1; state_in = WIKI_IN; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    check("mid-run col2", mc_in, col_of(WIKI_IN, 2));
    rst_n = 1'b0;
    #1;
    check("abort busy", busy, 1'b0);
    check("abort out_valid", out_valid, 1'b0);
    check("abort state_out", state_out, 128'h0);
    check("abort mc_in", mc_in, 32'h0);
    tick();
    check("abort no out_valid", out_valid, 1'b0);
    rst_n = 1'b1;
    tick();
    run_op("after reset", 1'b1, WIKI_IN, WIKI_OUT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
